div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle signed 32-bit divider, the iterative counterpart of the datapath's combinational multiplier. The control unit issues a one-cycle `start` with the Y operand (dividend) and bus operand (divisor). The block runs a restoring shift/subtract sequence, one quotient bit per clock. It returns a 64-bit Z word in the same format the ALU places in Z: upper half is the remainder (HI), lower half is the quotient (LO).

## Interface
- `REG_SIZE`, 32, operand width; Z result is 2*REG_SIZE.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `y_data_in`  in  REG_SIZE  dividend, two's complement; captured on accepted start.
- `bus_data_in`  in  REG_SIZE  divisor, two's complement; captured on accepted start.
- `z_data_out`  out  2*REG_SIZE  {remainder, quotient}; registered; holds until next completion.
- `busy`  out  1  high from the edge after accept through the final iteration.
- `done`  out  1  one-cycle pulse when `z_data_out` is updated.
- `div_by_zero`  out  1  registered with `z_data_out`; high if the last completed operation had divisor 0.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, `start`=1, divisor≠0:
  - Latch sign_q = sign(y) XOR sign(bus) and sign_r = sign(y).
  - Load magnitude |y| into the quotient shift register and |bus| into the divisor register.
  - Clear partial remainder (REG_SIZE+1 bits) and count.
  - Next state ITER.
- Magnitudes are taken as REG_SIZE-bit unsigned values, so |−2^31| = 0x80000000 is valid.
- IDLE, `start`=1, divisor=0:
  - Go directly to FIX with div_by_zero forced.
  - Result is {y_data_in, all ones}.
- ITER, once per edge:
  - Shift {rem, quo} left 1.
  - Compute trial = rem − divisor.
  - If trial is non-negative: rem = trial and quo[0] = 1; else quo[0] = 0.
  - count++. After REG_SIZE iterations, go to FIX.
- FIX:
  - Quotient = sign_q ? −quo : quo.
  - Remainder = sign_r ? −rem : rem (remainder takes the dividend's sign; truncating division).
  - Write `z_data_out` and `div_by_zero`, pulse `done`, return to IDLE.
- Overflow case 0x80000000 / −1: the quotient wraps to 0x80000000 and the remainder is 0. No flag is raised.
- `start` while not IDLE is ignored. No queueing, no abort.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- Operands are captured at accept. Later changes on the inputs have no effect on the running operation.

## Timing
- Reset (`clr_n`=0, any time, including mid-operation):
  - State IDLE, count 0.
  - `z_data_out`=0, `busy`=0, `done`=0, `div_by_zero`=0.
  - No `done` is emitted for an interrupted operation.
- Accept edge E0, divisor≠0:
  - `busy`=1 after E0.
  - Iterations occur on E1..E_REG_SIZE.
  - FIX edge E_(REG_SIZE+1) updates `z_data_out` and sets `done`=1 for one cycle; `busy` drops at that same edge.
  - Total latency is REG_SIZE+1 edges (33 at default).
- Accept edge E0, divisor=0: `busy` is high for one cycle; result and `done` are updated at E1 (latency 1).
- Back-to-back throughput is one operation per REG_SIZE+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `done` never lasts more than one cycle.

## Test plan
- y=100, bus=7, pulse start → `done` 33 edges after accept, z=0x00000002_0000000E, div_by_zero=0.
- y=−100 (0xFFFFFF9C), bus=7 → z=0xFFFFFFFE_FFFFFFF2 (r=−2, q=−14). Also y=100, bus=−7 → z=0x00000002_FFFFFFF2.
- y=5, bus=0 → `done` 1 edge after accept, z=0x00000005_FFFFFFFF, div_by_zero=1. A following 9/3 gives z=0x00000000_00000003 and div_by_zero=0.
- y=0x80000000, bus=0xFFFFFFFF → z=0x00000000_80000000. Also y=7, bus=100 → z=0x00000007_00000000.
- Start 100/7, pulse start again with 50/5 at iteration 5 → second start ignored, single `done`, z=0x00000002_0000000E. Then a start in the `done` cycle is accepted.
- Start 100/7, assert `clr_n`=0 at iteration 10 → all outputs 0 immediately (asynchronous), no `done`. After release, 9/3 completes normally in 33 edges.

Source files
------------

// File: rtl/div_seq.sv
// Iterative signed divider: restoring shift/subtract, one quotient bit per clock.
// Result packs {remainder, quotient}; truncating division, remainder follows dividend sign.
module div_seq #(
  parameter int unsigned REG_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    start,
  input  logic [REG_SIZE-1:0]     y_data_in,
  input  logic [REG_SIZE-1:0]     bus_data_in,
  output logic [2*REG_SIZE-1:0]   z_data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int unsigned CW = $clog2(REG_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       count_q;
  logic [REG_SIZE-1:0] rem_q;
  logic [REG_SIZE-1:0] quo_q;
  logic [REG_SIZE-1:0] div_q;
  logic                sgn_quo_q;
  logic                sgn_rem_q;
  logic                dbz_q;

  logic [REG_SIZE-1:0] y_mag_c;
  logic [REG_SIZE-1:0] bus_mag_c;
  logic [REG_SIZE:0]   rem_sh_c;
  logic [REG_SIZE:0]   trial_c;
  logic [REG_SIZE-1:0] rem_d;
  logic [REG_SIZE-1:0] quo_d;
  logic [REG_SIZE-1:0] quo_fix_c;
  logic [REG_SIZE-1:0] rem_fix_c;

  // Operand magnitudes, one restoring step, and sign fix-up of the final result.
  always_comb begin
    y_mag_c   = y_data_in[REG_SIZE-1]   ? -y_data_in   : y_data_in;
    bus_mag_c = bus_data_in[REG_SIZE-1] ? -bus_data_in : bus_data_in;
    rem_sh_c  = {rem_q, quo_q[REG_SIZE-1]};
    trial_c   = rem_sh_c - {1'b0, div_q};
    // A negative trial means the shifted remainder is below the divisor, so its top bit is clear.
    rem_d     = trial_c[REG_SIZE] ? rem_sh_c[REG_SIZE-1:0] : trial_c[REG_SIZE-1:0];
    quo_d     = {quo_q[REG_SIZE-2:0], ~trial_c[REG_SIZE]};
    quo_fix_c = sgn_quo_q ? -quo_q : quo_q;
    rem_fix_c = sgn_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      sgn_quo_q   <= 1'b0;
      sgn_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      z_data_out  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            count_q <= '0;
            if (bus_data_in == '0) begin
              // Zero divisor skips iteration; FIX emits {dividend, all ones} unchanged.
              rem_q     <= y_data_in;
              quo_q     <= '1;
              div_q     <= '0;
              sgn_quo_q <= 1'b0;
              sgn_rem_q <= 1'b0;
              dbz_q     <= 1'b1;
              state_q   <= S_FIX;
            end else begin
              rem_q     <= '0;
              quo_q     <= y_mag_c;
              div_q     <= bus_mag_c;
              sgn_quo_q <= y_data_in[REG_SIZE-1] ^ bus_data_in[REG_SIZE-1];
              sgn_rem_q <= y_data_in[REG_SIZE-1];
              dbz_q     <= 1'b0;
              state_q   <= S_ITER;
            end
          end
        end
        S_ITER: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(REG_SIZE - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          z_data_out  <= {rem_fix_c, quo_fix_c};
          div_by_zero <= dbz_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed test-plan cases plus randomized traffic, all checked
// every cycle against an arithmetic model of the divider's externally visible behaviour.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] y_data_in = '0;
  logic [31:0] bus_data_in = '0;
  logic [63:0] z_data_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  div_seq #(.REG_SIZE(32)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .y_data_in   (y_data_in),
    .bus_data_in (bus_data_in),
    .z_data_out  (z_data_out),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Truncating signed division result {remainder, quotient}
  function automatic logic [63:0] ref_z(input logic [31:0] y, input logic [31:0] b);
    int sy;
    int sb;
    int q;
    int r;
    if (b == 32'h0) return {y, 32'hFFFF_FFFF};
    if (y == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sy = $signed(y);
    sb = $signed(b);
    q = sy / sb;
    r = sy % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: an accepted op completes a fixed number of edges later; starts while running are dropped.
  int          m_rem = 0;
  logic [63:0] m_z = '0;
  logic [63:0] m_pz = '0;
  bit          m_dbz = 1'b0;
  bit          m_pdbz = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_rem = 0; m_z = '0; m_dbz = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_z = m_pz; m_dbz = m_pdbz; m_done = 1'b1;
        end
      end else if (start) begin
        m_rem  = (bus_data_in == 32'h0) ? 1 : 33;
        m_pz   = ref_z(y_data_in, bus_data_in);
        m_pdbz = (bus_data_in == 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("z", z_data_out, m_z);
      chk("busy", 64'(busy), 64'(m_rem > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      chk("busy_and_done", 64'(busy & done), 64'h0);
    end
  end

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait (bounded) for done; check latency and result against literals.
  task automatic do_op(input string nm, input logic [31:0] y, input logic [31:0] b,
                       input logic [63:0] exp_z, input int exp_edges);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; y_data_in = y; bus_data_in = b;
    lat = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b0; y_data_in = $urandom; bus_data_in = $urandom;
    lat = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end else begin
      chk({nm, "_z"}, z_data_out, exp_z);
      chk({nm, "_latency"}, 64'(lat - 1), 64'(exp_edges));
    end
  endtask

  initial begin
    int dones;
    // Pin the model on hand-computed values
    chk("ref_100_7",   ref_z(32'd100, 32'd7), 64'h00000002_0000000E);
    chk("ref_m100_7",  ref_z(32'hFFFFFF9C, 32'd7), 64'hFFFFFFFE_FFFFFFF2);
    chk("ref_100_m7",  ref_z(32'd100, 32'hFFFFFFF9), 64'h00000002_FFFFFFF2);
    chk("ref_5_0",     ref_z(32'd5, 32'd0), 64'h00000005_FFFFFFFF);
    chk("ref_min_m1",  ref_z(32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("ref_7_100",   ref_z(32'd7, 32'd100), 64'h00000007_00000000);

    #1 clr_n = 1'b0;
    #1;
    chk("rst_z", z_data_out, 64'h0);
    chk("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
    @(negedge clk);
    clr_n = 1'b1;
    chk_en = 1'b1;

    do_op("d_100_7",   32'd100, 32'd7, 64'h00000002_0000000E, 33);
    do_op("d_m100_7",  32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);
    do_op("d_100_m7",  32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33);
    do_op("d_5_0",     32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1);
    chk("d_5_0_dbz", 64'(div_by_zero), 64'h1);
    do_op("d_9_3",     32'd9, 32'd3, 64'h00000000_00000003, 33);
    chk("d_9_3_dbz", 64'(div_by_zero), 64'h0);
    do_op("d_min_m1",  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_op("d_7_100",   32'd7, 32'd100, 64'h00000007_00000000, 33);

    // Second start mid-operation is ignored; a start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; y_data_in = 32'd100; bus_data_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; y_data_in = 32'd50; bus_data_in = 32'd5;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_done_seen", 64'(dones), 64'h1);
    chk("ign_z", z_data_out, 64'h00000002_0000000E);
    start = 1'b1; y_data_in = 32'd9; bus_data_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("b2b_z", z_data_out, 64'h00000000_00000003);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; y_data_in = 32'd100; bus_data_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_z", z_data_out, 64'h0);
    chk("arst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_no_done", 64'(dones), 64'h0);
    do_op("d_post_rst", 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Randomized traffic, including starts while busy and changing operands
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      y_data_in = rand_opnd();
      bus_data_in = rand_opnd();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
